ysyx_25040111_arbiter_n: RTL and testbench
==========================================

# ysyx_25040111_arbiter_n

Parametrised N-channel memory arbiter between the core's bus masters (icache refill, EXU load/store, and future masters such as a dcache or DMA) and the single LSU read/write port. It grants one latched request at a time, under fixed-priority or round-robin policy. Read bursts of up to 256 beats are routed beat-by-beat back to the granted channel. It is the generalised successor of the two-master icache/EXU arbiter.

## Interface
- NCH, 2, number of request channels (1..8); channel index width CW = max(1, clog2(NCH))
- AW, 32, address width
- DW, 32, data width
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NCH  per-channel request; must be held until req_ready
- req_ready  out  NCH  one-cycle completion pulse to the granted channel
- req_write  in  NCH  1 = write, 0 = read
- req_addr  in  NCH*AW  flattened address, channel i at [i*AW +: AW]
- req_wdata  in  NCH*DW  flattened write data
- req_mask  in  NCH*2  access size: 00 byte, 01 half, 10 word
- req_rsign  in  NCH  sign-extend read data
- req_rlen  in  NCH*8  read burst length minus one (0 = single beat)
- resp_data  out  DW  read beat data (lsu_rdata pass-through)
- resp_beat  out  NCH  one-hot; resp_data is valid for that channel this cycle
- lsu_rvalid / lsu_rready  out / in  1  read request and per-beat data strobe
- lsu_raddr, lsu_rlen, lsu_rmask, lsu_rsign, lsu_burst  out  AW, 8, 2, 1, 1  latched read fields; lsu_burst = (rlen != 0)
- lsu_rdata  in  DW  read beat data
- lsu_wvalid / lsu_wready  out / in  1  write request and completion
- lsu_waddr, lsu_wdata, lsu_wmask  out  AW, DW, 2  latched write fields

## Operation
- States: IDLE, RD, WR.
- IDLE:
  - If any req_valid is high, select a winner.
  - RR_MODE=0: the lowest index wins.
  - RR_MODE=1: the first valid index at or after pointer ptr, wrapping mod NCH, wins. Then ptr <= winner+1, wrapping NCH-1 to 0.
  - Latch winner index g, address, wdata, mask, rsign and rlen. Clear the beat counter.
  - Go to RD or WR according to req_write[g].
- RD:
  - lsu_rvalid = 1.
  - On each cycle with lsu_rready = 1: resp_beat[g] = 1 and the beat counter increments (8-bit).
  - The beat where counter == rlen is the last beat. On that beat req_ready[g] = 1 and the state returns to IDLE.
- WR:
  - lsu_wvalid = 1.
  - On lsu_wready = 1: req_ready[g] = 1 and the state returns to IDLE.
- Latched fields are stable for the whole transaction.
- Changes on req_* from any channel during RD/WR are ignored, including deassertion of the granted channel's req_valid.
- Valid channels that lose arbitration stay pending. No request is lost.
- lsu_rready or lsu_wready asserted in a state that does not expect it is ignored.

## Timing
- Reset (reset = 0 at a clock edge):
  - State becomes IDLE, ptr = 0, the beat counter clears, and any in-flight transaction is dropped.
  - All outputs are 0: req_ready, resp_beat, lsu_rvalid, lsu_wvalid, all lsu_* address/data/mask fields, and resp_data apart from its pass-through.
- Grant latency: a request seen in IDLE at cycle t gives lsu_*valid = 1 at cycle t+1.
- req_ready and resp_beat are combinational from lsu_rready/lsu_wready in the same cycle. Minimum single-beat latency is 1 cycle after request capture.
- Completion cycle:
  - No new grant is made.
  - IDLE lasts at least one cycle between transactions, giving a 1-cycle bubble back-to-back.
- Burst of rlen = 255 produces exactly 256 resp_beat pulses. The counter does not wrap past the last beat.
- Simultaneous requests in round-robin mode are served in rotating order. Every valid channel is granted within NCH transactions, so there is no starvation.
- NCH = 1: the arbitration logic degenerates, and behaviour is otherwise identical.

## Test plan
- Single read: NCH=2, ch1 requests addr 0x8000_0010 with rlen=0 and lsu_rready one cycle after lsu_rvalid rises -> lsu_raddr = 0x8000_0010, lsu_burst = 0, one resp_beat = 2'b10, and req_ready = 2'b10 in the same cycle.
- Burst read: ch0 with rlen=7 and lsu_rready asserted on alternate cycles -> 8 resp_beat[0] pulses carrying data 0..7 in order, req_ready[0] only on the 8th beat, then return to IDLE.
- Fixed vs round-robin: NCH=3 with all three channels continuously valid. RR_MODE=0 -> ch0 is granted every time. RR_MODE=1 -> grant order is 0,1,2,0.
- Write: ch2 writes 0xDEAD_BEEF with mask 10 and lsu_wready delayed 5 cycles -> lsu_wvalid is held for 6 cycles with lsu_wdata stable, then req_ready[2] pulses once.
- Reset mid-burst: reset = 0 on the 3rd beat of an rlen=7 read -> next cycle all outputs are 0 and state is IDLE. After reset is released, a still-valid request is re-granted from ptr = 0.
- Ignored changes: the granted channel drops req_valid and another channel changes req_addr mid-RD -> lsu_raddr is unchanged and the burst completes normally.

Source files
------------

// File: rtl/ysyx_25040111_arbiter_n_if.sv
// ysyx_25040111_arbiter_n_if
// Bundles the request side (N channels) and the LSU side of the arbiter.
//   master modport : the arbiter's view (takes channel requests, drives LSU)
//   slave  modport : the environment's view (requesters + LSU)
// Channel-indexed fields are flattened: channel i lives at [i*W +: W].
interface ysyx_25040111_arbiter_n_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  // channel request side
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    req_write;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*2-1:0]  req_mask;
  logic [NCH-1:0]    req_rsign;
  logic [NCH*8-1:0]  req_rlen;
  logic [DW-1:0]     resp_data;
  logic [NCH-1:0]    resp_beat;
  // LSU read port
  logic              lsu_rvalid;
  logic              lsu_rready;
  logic [AW-1:0]     lsu_raddr;
  logic [7:0]        lsu_rlen;
  logic [1:0]        lsu_rmask;
  logic              lsu_rsign;
  logic              lsu_burst;
  logic [DW-1:0]     lsu_rdata;
  // LSU write port
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic [AW-1:0]     lsu_waddr;
  logic [DW-1:0]     lsu_wdata;
  logic [1:0]        lsu_wmask;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, req_rsign, req_rlen,
    output req_ready, resp_data, resp_beat,
    output lsu_rvalid, lsu_raddr, lsu_rlen, lsu_rmask, lsu_rsign, lsu_burst,
    input  lsu_rready, lsu_rdata,
    output lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask,
    input  lsu_wready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_mask, req_rsign, req_rlen,
    input  req_ready, resp_data, resp_beat,
    input  lsu_rvalid, lsu_raddr, lsu_rlen, lsu_rmask, lsu_rsign, lsu_burst,
    output lsu_rready, lsu_rdata,
    input  lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask,
    output lsu_wready
  );
endinterface

// File: rtl/ysyx_25040111_arbiter_n.sv
// ysyx_25040111_arbiter_n
// N-channel arbiter in front of the single LSU read/write port. One request
// is latched at a time (fixed priority or round-robin), then either a read
// burst of rlen+1 beats or a single write is carried out on the LSU.
//   clock : system clock
//   reset : synchronous, active-low
//   bus   : request channels + LSU port (master modport)
module ysyx_25040111_arbiter_n #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  ysyx_25040111_arbiter_n_if.master bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] g_reg, g_next;
  logic [CW-1:0] ptr_reg, ptr_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [1:0]    mask_reg, mask_next;
  logic          rsign_reg, rsign_next;
  logic [7:0]    rlen_reg, rlen_next;
  logic [7:0]    cnt_reg, cnt_next;

  // per-channel views of the flattened request fields
  logic [AW-1:0] addr_ch  [NCH];
  logic [DW-1:0] wdata_ch [NCH];
  logic [1:0]    mask_ch  [NCH];
  logic [7:0]    rlen_ch  [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign addr_ch[gi]  = bus.req_addr[gi*AW +: AW];
      assign wdata_ch[gi] = bus.req_wdata[gi*DW +: DW];
      assign mask_ch[gi]  = bus.req_mask[gi*2 +: 2];
      assign rlen_ch[gi]  = bus.req_rlen[gi*8 +: 8];
    end
  endgenerate

  // Winner search: scan NCH slots starting at ptr (round-robin) or at 0
  // (fixed priority); the first valid slot wins. idx carries one extra bit
  // so ptr+k can exceed NCH-1 before being folded back.
  logic          found;
  logic [CW-1:0] win;
  logic [CW:0]   idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (RR_MODE != 0) idx = {1'b0, ptr_reg} + (CW+1)'(k);
      else              idx = (CW+1)'(k);
      if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
      if (!found && bus.req_valid[idx[CW-1:0]]) begin
        found = 1'b1;
        win   = idx[CW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      ptr_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      mask_reg  <= '0;
      rsign_reg <= 1'b0;
      rlen_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      ptr_reg   <= ptr_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      mask_reg  <= mask_next;
      rsign_reg <= rsign_next;
      rlen_reg  <= rlen_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    g_next         = g_reg;
    ptr_next       = ptr_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    mask_next      = mask_reg;
    rsign_next     = rsign_reg;
    rlen_next      = rlen_reg;
    cnt_next       = cnt_reg;
    bus.req_ready  = '0;
    bus.resp_beat  = '0;
    bus.lsu_rvalid = 1'b0;
    bus.lsu_wvalid = 1'b0;

    case (state_reg)
      IDLE: begin
        if (found) begin
          g_next     = win;
          addr_next  = addr_ch[win];
          wdata_next = wdata_ch[win];
          mask_next  = mask_ch[win];
          rsign_next = bus.req_rsign[win];
          rlen_next  = rlen_ch[win];
          cnt_next   = '0;
          if (RR_MODE != 0)
            ptr_next = (win == CW'(NCH-1)) ? '0 : win + CW'(1);
          state_next = bus.req_write[win] ? WR : RD;
        end
      end
      RD: begin
        bus.lsu_rvalid = 1'b1;
        if (bus.lsu_rready) begin
          bus.resp_beat[g_reg] = 1'b1;
          if (cnt_reg == rlen_reg) begin
            // last beat: counter parks at 0 instead of wrapping past rlen
            bus.req_ready[g_reg] = 1'b1;
            cnt_next             = '0;
            state_next           = IDLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      WR: begin
        bus.lsu_wvalid = 1'b1;
        if (bus.lsu_wready) begin
          bus.req_ready[g_reg] = 1'b1;
          state_next           = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.resp_data = bus.lsu_rdata;
  assign bus.lsu_raddr = addr_reg;
  assign bus.lsu_rlen  = rlen_reg;
  assign bus.lsu_rmask = mask_reg;
  assign bus.lsu_rsign = rsign_reg;
  assign bus.lsu_burst = (rlen_reg != 8'd0);
  assign bus.lsu_waddr = addr_reg;
  assign bus.lsu_wdata = wdata_reg;
  assign bus.lsu_wmask = mask_reg;
endmodule

// File: tb/tb_ysyx_25040111_arbiter_n.sv
module tb_ysyx_25040111_arbiter_n;
  localparam int N = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_25040111_arbiter_n_if #(.NCH(N), .AW(32), .DW(32)) bus ();
  ysyx_25040111_arbiter_n_if #(.NCH(N), .AW(32), .DW(32)) fbus ();

  ysyx_25040111_arbiter_n #(.NCH(N), .AW(32), .DW(32), .RR_MODE(1)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  ysyx_25040111_arbiter_n #(.NCH(N), .AW(32), .DW(32), .RR_MODE(0)) dut_fp (
    .clock(clock), .reset(reset), .bus(fbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: pending requests per channel and the rotation pointer
  bit          pend    [N];
  bit          m_wr    [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_wdata [N];
  logic [1:0]  m_mask  [N];
  bit          m_rsign [N];
  logic [7:0]  m_rlen  [N];
  int          mptr;
  int          txn_no;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = pend[c];
    return v;
  endfunction

  // first valid channel at or after p (rr) or from 0 (fixed)
  function automatic int pick(input bit rr, input int p, input logic [N-1:0] pv);
    for (int k = 0; k < N; k++) begin
      int c;
      c = rr ? (p + k) % N : k;
      if (pv[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_ch(input int c);
    bus.req_valid[c]          = pend[c];
    bus.req_write[c]          = m_wr[c];
    bus.req_addr[c*32 +: 32]  = m_addr[c];
    bus.req_wdata[c*32 +: 32] = m_wdata[c];
    bus.req_mask[c*2 +: 2]    = m_mask[c];
    bus.req_rsign[c]          = m_rsign[c];
    bus.req_rlen[c*8 +: 8]    = m_rlen[c];
  endtask

  task automatic gen_req(input int c);
    pend[c]    = 1'b1;
    m_wr[c]    = ($urandom_range(0, 2) == 0);
    m_addr[c]  = $urandom;
    m_wdata[c] = $urandom;
    m_mask[c]  = 2'($urandom_range(0, 2));
    m_rsign[c] = 1'($urandom_range(0, 1));
    m_rlen[c]  = 8'($urandom_range(0, 7));
    drive_ch(c);
  endtask

  // One full transaction on the round-robin DUT, starting in an IDLE cycle
  // with the requests already driven.
  task automatic do_txn();
    int w, cyc, beats, obs;
    bit done, rdy;
    logic [N-1:0] oh;
    logic [31:0] rd;
    w = pick(1'b1, mptr, pend_vec());
    if (w < 0) return;
    mptr = (w + 1) % N;
    oh = '0;
    oh[w] = 1'b1;
    #1;
    check_eq("idle_valid", {bus.lsu_rvalid, bus.lsu_wvalid}, 2'b00);
    check_eq("idle_ready", bus.req_ready, '0);
    step();
    check_eq("grant_rvalid", bus.lsu_rvalid, !m_wr[w]);
    check_eq("grant_wvalid", bus.lsu_wvalid, m_wr[w]);
    if (!m_wr[w]) begin
      check_eq("raddr", bus.lsu_raddr, m_addr[w]);
      check_eq("rlen", bus.lsu_rlen, m_rlen[w]);
      check_eq("rmask", bus.lsu_rmask, m_mask[w]);
      check_eq("rsign", bus.lsu_rsign, m_rsign[w]);
      check_eq("burst", bus.lsu_burst, m_rlen[w] != 8'd0);
    end else begin
      check_eq("waddr", bus.lsu_waddr, m_addr[w]);
      check_eq("wdata", bus.lsu_wdata, m_wdata[w]);
      check_eq("wmask", bus.lsu_wmask, m_mask[w]);
    end
    cyc = 0; beats = 0; obs = 0; done = 1'b0;
    while (!done && cyc < 2000) begin
      rdy = 1'($urandom_range(0, 1));
      rd  = $urandom;
      bus.lsu_rdata = rd;
      if (m_wr[w]) begin
        bus.lsu_wready = rdy;
        bus.lsu_rready = 1'($urandom_range(0, 1));
      end else begin
        bus.lsu_rready = rdy;
        bus.lsu_wready = 1'($urandom_range(0, 1));
      end
      // disturbances that must be ignored while busy
      for (int c = 0; c < N; c++)
        if (!pend[c]) begin
          bus.req_addr[c*32 +: 32] = $urandom;
          bus.req_write[c] = 1'($urandom_range(0, 1));
        end
      if ($urandom_range(0, 3) == 0) bus.req_valid[w] = 1'b0;
      if ($urandom_range(0, 3) == 0) bus.req_addr[w*32 +: 32] = $urandom;
      #1;
      if (!m_wr[w]) begin
        check_eq("rd_raddr_stable", bus.lsu_raddr, m_addr[w]);
        check_eq("rd_rvalid", bus.lsu_rvalid, 1'b1);
        check_eq("rd_data", bus.resp_data, rd);
        check_eq("rd_beat", bus.resp_beat, rdy ? oh : '0);
        check_eq("rd_ready", bus.req_ready, (rdy && beats == int'(m_rlen[w])) ? oh : '0);
        if (bus.resp_beat[w]) obs++;
        if (rdy) begin
          if (beats == int'(m_rlen[w])) done = 1'b1;
          beats++;
        end
      end else begin
        check_eq("wr_wdata_stable", bus.lsu_wdata, m_wdata[w]);
        check_eq("wr_wvalid", bus.lsu_wvalid, 1'b1);
        check_eq("wr_beat", bus.resp_beat, '0);
        check_eq("wr_ready", bus.req_ready, rdy ? oh : '0);
        if (rdy) done = 1'b1;
      end
      step();
      cyc++;
    end
    if (!done) check_eq("txn_timeout", 1'b0, 1'b1);
    if (!m_wr[w]) check_eq("beat_count", 64'(obs), 64'(int'(m_rlen[w]) + 1));
    pend[w] = 1'b0;
    bus.req_valid[w] = 1'b0;
    bus.lsu_rready = 1'b0;
    bus.lsu_wready = 1'b0;
    $display("txn %0d: ch%0d %s addr=0x%08h rlen=%0d beats=%0d cycles=%0d",
             txn_no, w, m_wr[w] ? "WR" : "RD", m_addr[w], m_rlen[w], obs, cyc);
    txn_no++;
  endtask

  initial begin
    reset = 1'b0;
    mptr = 0;
    txn_no = 0;
    for (int c = 0; c < N; c++) begin
      pend[c] = 1'b0; m_wr[c] = 1'b0; m_addr[c] = '0; m_wdata[c] = '0;
      m_mask[c] = '0; m_rsign[c] = 1'b0; m_rlen[c] = '0;
    end
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_mask = '0; bus.req_rsign = '0; bus.req_rlen = '0;
    bus.lsu_rready = 1'b0; bus.lsu_wready = 1'b0; bus.lsu_rdata = '0;
    fbus.req_valid = '0; fbus.req_write = '0; fbus.req_addr = '0; fbus.req_wdata = '0;
    fbus.req_mask = '0; fbus.req_rsign = '0; fbus.req_rlen = '0;
    fbus.lsu_rready = 1'b0; fbus.lsu_wready = 1'b0; fbus.lsu_rdata = '0;
    step();
    step();
    check_eq("rst_valid", {bus.lsu_rvalid, bus.lsu_wvalid, bus.req_ready, bus.resp_beat}, '0);
    check_eq("rst_rfields", {bus.lsu_raddr, bus.lsu_rlen, bus.lsu_rmask, bus.lsu_rsign, bus.lsu_burst}, '0);
    check_eq("rst_wfields", {bus.lsu_waddr, bus.lsu_wdata, bus.lsu_wmask}, '0);
    reset = 1'b1;
    step();

    // randomized round-robin traffic
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < N; c++)
        if (!pend[c] && $urandom_range(0, 1) == 1) gen_req(c);
      if (pend_vec() == '0) gen_req(int'($urandom_range(0, N-1)));
      for (int c = 0; c < N; c++) drive_ch(c);
      do_txn();
    end
    for (int k = 0; k < N && pend_vec() != '0; k++) begin
      for (int c = 0; c < N; c++) drive_ch(c);
      do_txn();
    end

    // longest burst: 256 beats
    gen_req(2);
    m_wr[2] = 1'b0;
    m_rlen[2] = 8'd255;
    drive_ch(2);
    do_txn();

    // reset on the 3rd beat of an rlen=7 read on ch1
    gen_req(1);
    m_wr[1] = 1'b0;
    m_rlen[1] = 8'd7;
    m_addr[1] = m_addr[1] | 32'h1;
    drive_ch(1);
    mptr = 2;
    #1;
    step();
    check_eq("mid_grant", bus.lsu_rvalid, 1'b1);
    bus.lsu_rready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    bus.lsu_rready = 1'b0;
    mptr = 0;
    #1;
    check_eq("midrst_valid", {bus.lsu_rvalid, bus.lsu_wvalid, bus.req_ready, bus.resp_beat}, '0);
    check_eq("midrst_rfields", {bus.lsu_raddr, bus.lsu_rlen, bus.lsu_rmask, bus.lsu_rsign, bus.lsu_burst}, '0);
    check_eq("midrst_wfields", {bus.lsu_waddr, bus.lsu_wdata, bus.lsu_wmask}, '0);
    reset = 1'b1;
    gen_req(2);
    drive_ch(1);
    do_txn();
    for (int k = 0; k < N && pend_vec() != '0; k++) begin
      for (int c = 0; c < N; c++) drive_ch(c);
      do_txn();
    end

    // fixed priority on the second instance: lowest valid index wins
    for (int t = 0; t < 8; t++) begin
      logic [N-1:0] pv;
      logic [N-1:0] oh;
      int w;
      pv = (t == 0) ? '1 : N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++) begin
        fbus.req_valid[c] = pv[c];
        fbus.req_write[c] = 1'b1;
        fbus.req_addr[c*32 +: 32] = 32'h8000_0000 + 32'(c) * 32'h100 + 32'(t);
        fbus.req_wdata[c*32 +: 32] = 32'hDEAD_0000 + 32'(c);
        fbus.req_mask[c*2 +: 2] = 2'b10;
      end
      w = pick(1'b0, 0, pv);
      oh = '0;
      oh[w] = 1'b1;
      #1;
      check_eq("fp_idle", fbus.lsu_wvalid, 1'b0);
      step();
      check_eq("fp_wvalid", fbus.lsu_wvalid, 1'b1);
      check_eq("fp_waddr", fbus.lsu_waddr, 32'h8000_0000 + 32'(w) * 32'h100 + 32'(t));
      check_eq("fp_wdata", fbus.lsu_wdata, 32'hDEAD_0000 + 32'(w));
      fbus.lsu_wready = 1'b1;
      #1;
      check_eq("fp_ready", fbus.req_ready, oh);
      step();
      fbus.lsu_wready = 1'b0;
      $display("fp txn %0d: valid=%b granted ch%0d", t, pv, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
